// File: rtl/scr1_tapc_mch_pkg.sv
// Shared types and constants for the multi-channel JTAG TAP controller.
package scr1_tapc_mch_pkg;

  // IEEE 1149.1 TAP controller states, in the usual SCR1 encoding
  typedef enum logic [3:0] {
    SCR1_TAP_STATE_RESET       = 4'd0,
    SCR1_TAP_STATE_IDLE        = 4'd1,
    SCR1_TAP_STATE_DR_SEL_SCAN = 4'd2,
    SCR1_TAP_STATE_DR_CAPTURE  = 4'd3,
    SCR1_TAP_STATE_DR_SHIFT    = 4'd4,
    SCR1_TAP_STATE_DR_EXIT1    = 4'd5,
    SCR1_TAP_STATE_DR_PAUSE    = 4'd6,
    SCR1_TAP_STATE_DR_EXIT2    = 4'd7,
    SCR1_TAP_STATE_DR_UPDATE   = 4'd8,
    SCR1_TAP_STATE_IR_SEL_SCAN = 4'd9,
    SCR1_TAP_STATE_IR_CAPTURE  = 4'd10,
    SCR1_TAP_STATE_IR_SHIFT    = 4'd11,
    SCR1_TAP_STATE_IR_EXIT1    = 4'd12,
    SCR1_TAP_STATE_IR_PAUSE    = 4'd13,
    SCR1_TAP_STATE_IR_EXIT2    = 4'd14,
    SCR1_TAP_STATE_IR_UPDATE   = 4'd15
  } type_scr1_tap_state_e;

  // Which data register currently sits between TDI and TDO
  typedef enum logic [1:0] {
    TAPC_DR_SEL_BYPASS = 2'd0,
    TAPC_DR_SEL_IDCODE = 2'd1,
    TAPC_DR_SEL_BLD_ID = 2'd2,
    TAPC_DR_SEL_CHAN   = 2'd3
  } type_tapc_dr_sel_e;

  // Built-in instruction codes, counted down from the all-ones code
  localparam int unsigned TAPC_BYPASS_OFS = 0;
  localparam int unsigned TAPC_IDCODE_OFS = 1;
  localparam int unsigned TAPC_BLD_ID_OFS = 2;

  // Built-in data register widths
  localparam int unsigned TAPC_BYPASS_DR_W = 1;
  localparam int unsigned TAPC_IDCODE_DR_W = 32;
  localparam int unsigned TAPC_BLD_ID_DR_W = 32;

  // Default build identifier reported through BLD_ID
  localparam logic [31:0] SCR1_TAPC_MCH_MIMPID = 32'h2201_1200;

  // TDO is only driven while a register is being shifted
  function automatic logic tapc_is_shift_state(input type_scr1_tap_state_e st);
    return (st == SCR1_TAP_STATE_IR_SHIFT) || (st == SCR1_TAP_STATE_DR_SHIFT);
  endfunction

endpackage

// File: rtl/scr1_tapc_mch_fsm.sv
// 16-state TAP controller: state register and TMS-driven next-state logic.
module scr1_tapc_mch_fsm
  import scr1_tapc_mch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tms,
  output logic [3:0] state
);

  type_scr1_tap_state_e state_q;
  type_scr1_tap_state_e state_d;

  // State register; reset lands in Test-Logic-Reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCR1_TAP_STATE_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Standard TMS transition table
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCR1_TAP_STATE_RESET:       state_d = tms ? SCR1_TAP_STATE_RESET       : SCR1_TAP_STATE_IDLE;
      SCR1_TAP_STATE_IDLE:        state_d = tms ? SCR1_TAP_STATE_DR_SEL_SCAN : SCR1_TAP_STATE_IDLE;
      SCR1_TAP_STATE_DR_SEL_SCAN: state_d = tms ? SCR1_TAP_STATE_IR_SEL_SCAN : SCR1_TAP_STATE_DR_CAPTURE;
      SCR1_TAP_STATE_DR_CAPTURE:  state_d = tms ? SCR1_TAP_STATE_DR_EXIT1    : SCR1_TAP_STATE_DR_SHIFT;
      SCR1_TAP_STATE_DR_SHIFT:    state_d = tms ? SCR1_TAP_STATE_DR_EXIT1    : SCR1_TAP_STATE_DR_SHIFT;
      SCR1_TAP_STATE_DR_EXIT1:    state_d = tms ? SCR1_TAP_STATE_DR_UPDATE   : SCR1_TAP_STATE_DR_PAUSE;
      SCR1_TAP_STATE_DR_PAUSE:    state_d = tms ? SCR1_TAP_STATE_DR_EXIT2    : SCR1_TAP_STATE_DR_PAUSE;
      SCR1_TAP_STATE_DR_EXIT2:    state_d = tms ? SCR1_TAP_STATE_DR_UPDATE   : SCR1_TAP_STATE_DR_SHIFT;
      SCR1_TAP_STATE_DR_UPDATE:   state_d = tms ? SCR1_TAP_STATE_DR_SEL_SCAN : SCR1_TAP_STATE_IDLE;
      SCR1_TAP_STATE_IR_SEL_SCAN: state_d = tms ? SCR1_TAP_STATE_RESET       : SCR1_TAP_STATE_IR_CAPTURE;
      SCR1_TAP_STATE_IR_CAPTURE:  state_d = tms ? SCR1_TAP_STATE_IR_EXIT1    : SCR1_TAP_STATE_IR_SHIFT;
      SCR1_TAP_STATE_IR_SHIFT:    state_d = tms ? SCR1_TAP_STATE_IR_EXIT1    : SCR1_TAP_STATE_IR_SHIFT;
      SCR1_TAP_STATE_IR_EXIT1:    state_d = tms ? SCR1_TAP_STATE_IR_UPDATE   : SCR1_TAP_STATE_IR_PAUSE;
      SCR1_TAP_STATE_IR_PAUSE:    state_d = tms ? SCR1_TAP_STATE_IR_EXIT2    : SCR1_TAP_STATE_IR_PAUSE;
      SCR1_TAP_STATE_IR_EXIT2:    state_d = tms ? SCR1_TAP_STATE_IR_UPDATE   : SCR1_TAP_STATE_IR_SHIFT;
      SCR1_TAP_STATE_IR_UPDATE:   state_d = tms ? SCR1_TAP_STATE_DR_SEL_SCAN : SCR1_TAP_STATE_IDLE;
      default:                    state_d = SCR1_TAP_STATE_RESET;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/scr1_tapc_mch.sv
// Multi-channel JTAG TAP controller: IR, built-in DRs (BYPASS/IDCODE/BLD_ID),
// channel decode and the falling-edge TDO path.
module scr1_tapc_mch
  import scr1_tapc_mch_pkg::*;
#(
  parameter int unsigned IR_WIDTH     = 5,
  parameter int unsigned CH_NUM       = 4,
  parameter int unsigned CH_BASE      = 'h03,
  parameter logic [31:0] IDCODE_VALUE = 32'hDEB01001,
  parameter logic [31:0] BLD_ID_VALUE = SCR1_TAPC_MCH_MIMPID
) (
  input  logic              tapc_tck,
  input  logic              tapc_trst_n,
  input  logic              tapc_tms,
  input  logic              tapc_tdi,
  output logic              tapc_tdo,
  output logic              tapc_tdo_en,
  output logic [CH_NUM-1:0] ch_sel,
  output logic              ch_capture,
  output logic              ch_shift,
  output logic              ch_update,
  output logic              ch_tdi,
  input  logic [CH_NUM-1:0] ch_tdo,
  output logic [3:0]        tapc_state
);

  localparam logic [IR_WIDTH-1:0] IR_ALL_ONES = '1;
  localparam logic [IR_WIDTH-1:0] IR_BYPASS   = IR_ALL_ONES - IR_WIDTH'(TAPC_BYPASS_OFS);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE   = IR_ALL_ONES - IR_WIDTH'(TAPC_IDCODE_OFS);
  localparam logic [IR_WIDTH-1:0] IR_BLD_ID   = IR_ALL_ONES - IR_WIDTH'(TAPC_BLD_ID_OFS);
  // Capture pattern: LSB pair 01, everything above zero
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(1);

  logic [3:0]           fsm_state;
  type_scr1_tap_state_e tap_state;

  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;

  logic [TAPC_BYPASS_DR_W-1:0] bypass_q, bypass_d;
  logic [TAPC_IDCODE_DR_W-1:0] idcode_q, idcode_d;
  logic [TAPC_BLD_ID_DR_W-1:0] bld_id_q, bld_id_d;

  logic [CH_NUM-1:0]  ch_hit;
  logic               ch_any;
  type_tapc_dr_sel_e  dr_sel;

  logic tdo_q, tdo_d;
  logic tdo_en_q, tdo_en_d;

  scr1_tapc_mch_fsm u_fsm (
    .clk   (tapc_tck),
    .rst_n (tapc_trst_n),
    .tms   (tapc_tms),
    .state (fsm_state)
  );

  assign tap_state  = type_scr1_tap_state_e'(fsm_state);
  assign tapc_state = fsm_state;

  // One comparator per channel against its instruction code
  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch_dec
      assign ch_hit[gi] = (ir_q == IR_WIDTH'(CH_BASE + gi));
    end
  endgenerate

  // Channel selection is masked in Test-Logic-Reset so that entering reset via
  // TMS deselects immediately, before the latched IR has been reloaded.
  assign ch_sel = (tap_state == SCR1_TAP_STATE_RESET) ? '0 : ch_hit;
  assign ch_any = |ch_sel;

  // Channel strobes are pure decodes of the state register so an async reset
  // drops them at once.
  assign ch_capture = ch_any && (tap_state == SCR1_TAP_STATE_DR_CAPTURE);
  assign ch_shift   = ch_any && (tap_state == SCR1_TAP_STATE_DR_SHIFT);
  assign ch_update  = ch_any && (tap_state == SCR1_TAP_STATE_DR_UPDATE);
  assign ch_tdi     = tapc_tdi;

  // Pick the DR that sits on the scan path; unknown codes fall back to BYPASS
  always_comb begin
    dr_sel = TAPC_DR_SEL_BYPASS;
    if (|ch_hit) begin
      dr_sel = TAPC_DR_SEL_CHAN;
    end else if (ir_q == IR_IDCODE) begin
      dr_sel = TAPC_DR_SEL_IDCODE;
    end else if (ir_q == IR_BLD_ID) begin
      dr_sel = TAPC_DR_SEL_BLD_ID;
    end else if (ir_q == IR_BYPASS) begin
      dr_sel = TAPC_DR_SEL_BYPASS;
    end
  end

  // Instruction register: capture/shift chain plus latched instruction
  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    case (tap_state)
      SCR1_TAP_STATE_RESET: begin
        ir_shift_d = '0;
        ir_d       = IR_IDCODE;
      end
      SCR1_TAP_STATE_IR_CAPTURE: ir_shift_d = IR_CAPTURE;
      SCR1_TAP_STATE_IR_SHIFT:   ir_shift_d = IR_WIDTH'({tapc_tdi, ir_shift_q} >> 1);
      SCR1_TAP_STATE_IR_UPDATE:  ir_d       = ir_shift_q;
      default: ;
    endcase
  end

  // IR flops
  always_ff @(posedge tapc_tck or negedge tapc_trst_n) begin
    if (!tapc_trst_n) begin
      ir_shift_q <= '0;
      ir_q       <= IR_IDCODE;
    end else begin
      ir_shift_q <= ir_shift_d;
      ir_q       <= ir_d;
    end
  end

  // Built-in read-only DRs: capture constant, shift right with TDI into MSB.
  // Pause/Exit states fall through to the hold defaults.
  always_comb begin
    bypass_d = bypass_q;
    idcode_d = idcode_q;
    bld_id_d = bld_id_q;
    case (tap_state)
      SCR1_TAP_STATE_RESET: begin
        bypass_d = '0;
        idcode_d = '0;
        bld_id_d = '0;
      end
      SCR1_TAP_STATE_DR_CAPTURE: begin
        case (dr_sel)
          TAPC_DR_SEL_BYPASS: bypass_d = '0;
          TAPC_DR_SEL_IDCODE: idcode_d = IDCODE_VALUE;
          TAPC_DR_SEL_BLD_ID: bld_id_d = BLD_ID_VALUE;
          default: ;
        endcase
      end
      SCR1_TAP_STATE_DR_SHIFT: begin
        case (dr_sel)
          TAPC_DR_SEL_BYPASS: bypass_d = TAPC_BYPASS_DR_W'({tapc_tdi, bypass_q} >> 1);
          TAPC_DR_SEL_IDCODE: idcode_d = TAPC_IDCODE_DR_W'({tapc_tdi, idcode_q} >> 1);
          TAPC_DR_SEL_BLD_ID: bld_id_d = TAPC_BLD_ID_DR_W'({tapc_tdi, bld_id_q} >> 1);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Built-in DR flops
  always_ff @(posedge tapc_tck or negedge tapc_trst_n) begin
    if (!tapc_trst_n) begin
      bypass_q <= '0;
      idcode_q <= '0;
      bld_id_q <= '0;
    end else begin
      bypass_q <= bypass_d;
      idcode_q <= idcode_d;
      bld_id_q <= bld_id_d;
    end
  end

  // TDO source mux; a selected channel is one-hot so an AND-OR picks its bit
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = tapc_is_shift_state(tap_state);
    if (tap_state == SCR1_TAP_STATE_IR_SHIFT) begin
      tdo_d = ir_shift_q[0];
    end else if (tap_state == SCR1_TAP_STATE_DR_SHIFT) begin
      case (dr_sel)
        TAPC_DR_SEL_IDCODE: tdo_d = idcode_q[0];
        TAPC_DR_SEL_BLD_ID: tdo_d = bld_id_q[0];
        TAPC_DR_SEL_CHAN:   tdo_d = |(ch_tdo & ch_hit);
        default:            tdo_d = bypass_q[0];
      endcase
    end
  end

  // TDO and its enable change on the falling edge, half a cycle after shifting
  always_ff @(negedge tapc_tck or negedge tapc_trst_n) begin
    if (!tapc_trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tapc_tdo    = tdo_q;
  assign tapc_tdo_en = tdo_en_q;

endmodule

// File: tb/tb_scr1_tapc_mch.sv
// Testbench for scr1_tapc_mch: JTAG-level scans checked against a scan-level model.
module tb_scr1_tapc_mch;
  import scr1_tapc_mch_pkg::*;

  localparam int unsigned IR_W   = 5;
  localparam int unsigned CH_N   = 4;
  localparam int unsigned CH_B   = 3;
  localparam int unsigned CH_DRW = 8;
  localparam logic [31:0] IDCODE = 32'hDEB01001;
  localparam logic [31:0] BLD_ID = 32'hB1D0_1234;
  localparam int unsigned C_BYP  = (1 << IR_W) - 1;
  localparam int unsigned C_IDC  = (1 << IR_W) - 2;
  localparam int unsigned C_BLD  = (1 << IR_W) - 3;

  logic            tck = 1'b0;
  logic            trst_n;
  logic            tms;
  logic            tdi;
  logic            tdo;
  logic            tdo_en;
  logic [CH_N-1:0] ch_sel;
  logic            ch_capture;
  logic            ch_shift;
  logic            ch_update;
  logic            ch_tdi;
  logic [CH_N-1:0] ch_tdo;
  logic [3:0]      tap_st;

  int n_vec = 0;
  int n_err = 0;
  int unsigned model_ir;

  // Emulated channel shift registers and strobe counters
  logic [CH_DRW-1:0] ch_sr      [CH_N];
  logic [CH_DRW-1:0] ch_cap_val [CH_N];
  int cap_cnt = 0;
  int shf_cnt = 0;
  int upd_cnt = 0;

  always #5 tck = ~tck;

  scr1_tapc_mch #(
    .IR_WIDTH     (IR_W),
    .CH_NUM       (CH_N),
    .CH_BASE      (CH_B),
    .IDCODE_VALUE (IDCODE),
    .BLD_ID_VALUE (BLD_ID)
  ) dut (
    .tapc_tck    (tck),
    .tapc_trst_n (trst_n),
    .tapc_tms    (tms),
    .tapc_tdi    (tdi),
    .tapc_tdo    (tdo),
    .tapc_tdo_en (tdo_en),
    .ch_sel      (ch_sel),
    .ch_capture  (ch_capture),
    .ch_shift    (ch_shift),
    .ch_update   (ch_update),
    .ch_tdi      (ch_tdi),
    .ch_tdo      (ch_tdo),
    .tapc_state  (tap_st)
  );

  generate
    for (genvar gi = 0; gi < CH_N; gi++) begin : g_ch_out
      assign ch_tdo[gi] = ch_sr[gi][0];
    end
  endgenerate

  // Behaviour of a channel-side DR owner plus strobe counting
  always @(posedge tck) begin
    if (ch_capture) cap_cnt <= cap_cnt + 1;
    if (ch_shift)   shf_cnt <= shf_cnt + 1;
    if (ch_update)  upd_cnt <= upd_cnt + 1;
    for (int k = 0; k < CH_N; k++) begin
      if (ch_sel[k] && ch_capture)    ch_sr[k] <= ch_cap_val[k];
      else if (ch_sel[k] && ch_shift) ch_sr[k] <= {ch_tdi, ch_sr[k][CH_DRW-1:1]};
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- scan-level reference model ----
  function automatic logic [CH_N-1:0] m_chsel(input int unsigned ir);
    if (ir >= CH_B && ir < CH_B + CH_N) return CH_N'(1) << (ir - CH_B);
    return '0;
  endfunction

  function automatic int unsigned m_width(input int unsigned ir);
    if (m_chsel(ir) != '0) return CH_DRW;
    if (ir == C_IDC || ir == C_BLD) return 32;
    return 1;
  endfunction

  function automatic logic [127:0] m_capture(input int unsigned ir);
    if (m_chsel(ir) != '0) return 128'(ch_cap_val[ir - CH_B]);
    if (ir == C_IDC) return 128'(IDCODE);
    if (ir == C_BLD) return 128'(BLD_ID);
    return '0;
  endfunction

  // ---- JTAG pin driving ----
  task automatic tck_cycle(input logic t_ms, input logic t_di, output logic o_do, output logic o_en);
    @(negedge tck);
    #1;
    o_do = tdo;
    o_en = tdo_en;
    tms  = t_ms;
    tdi  = t_di;
    @(posedge tck);
  endtask

  task automatic step(input logic t_ms);
    logic d0, d1;
    tck_cycle(t_ms, 1'b0, d0, d1);
  endtask

  // From Run-Test/Idle: load an instruction, return to Run-Test/Idle
  task automatic ir_scan(input int unsigned code, output logic [31:0] out, output logic en_ok);
    logic b, e;
    logic [31:0] cv;
    cv = 32'(code);
    out = '0;
    en_ok = 1'b1;
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < IR_W; i++) begin
      tck_cycle(i == IR_W - 1, cv[i], b, e);
      out[i] = b;
      en_ok &= e;
    end
    step(1'b1); step(1'b0);
    model_ir = code;
  endtask

  // From Run-Test/Idle: scan len DR bits, optional pause after bit pause_at
  task automatic dr_scan(input int len, input logic [63:0] din, input int pause_at,
                         output logic [63:0] out, output logic en_ok);
    logic b, e;
    out = '0;
    en_ok = 1'b1;
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < len; i++) begin
      tck_cycle((i == len - 1) || (i == pause_at), din[i], b, e);
      out[i] = b;
      en_ok &= e;
      if (i == pause_at && i != len - 1) begin
        tck_cycle(1'b0, 1'b0, b, e); en_ok &= !e;
        tck_cycle(1'b0, 1'b0, b, e); en_ok &= !e;
        tck_cycle(1'b0, 1'b0, b, e); en_ok &= !e;
        tck_cycle(1'b1, 1'b0, b, e); en_ok &= !e;
        tck_cycle(1'b0, 1'b0, b, e); en_ok &= !e;
      end
    end
    step(1'b1); step(1'b0);
  endtask

  // Full DR transaction checked against the model
  task automatic dr_txn(input string tag, input int len, input logic [63:0] din, input int pause_at);
    logic [63:0]  out;
    logic         en_ok;
    logic [127:0] exp, mask;
    int unsigned  w;
    int c0, s0, u0;
    w    = m_width(model_ir);
    mask = (128'd1 << len) - 128'd1;
    exp  = (m_capture(model_ir) | (128'(din) << w)) & mask;
    c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
    dr_scan(len, din, pause_at, out, en_ok);
    #1;
    $display("dr  %s ir=%0h len=%0d pause=%0d tdi=%0h tdo=%0h", tag, model_ir, len, pause_at, din, out);
    chk({tag, "_tdo"}, 128'(out), exp);
    chk({tag, "_tdo_en"}, 128'(en_ok), 128'd1);
    chk({tag, "_sel_hold"}, 128'(ch_sel), 128'(m_chsel(model_ir)));
    if (m_chsel(model_ir) != '0) begin
      chk({tag, "_strobes"}, {32'(cap_cnt - c0), 32'(shf_cnt - s0), 32'(upd_cnt - u0)},
          {32'd1, 32'(len), 32'd1});
      chk({tag, "_chan_reg"}, 128'(ch_sr[model_ir - CH_B]),
          ((m_capture(model_ir) | (128'(din) << CH_DRW)) >> len) & 128'hFF);
    end else begin
      chk({tag, "_no_strobes"}, {32'(cap_cnt - c0), 32'(shf_cnt - s0), 32'(upd_cnt - u0)}, '0);
    end
  endtask

  task automatic ir_txn(input string tag, input int unsigned code);
    logic [31:0] out;
    logic        en_ok;
    ir_scan(code, out, en_ok);
    #1;
    $display("ir  %s code=%0h tdo=%0h ch_sel=%0b", tag, code, out, ch_sel);
    chk({tag, "_ir_cap"}, 128'(out), 128'd1);
    chk({tag, "_ir_en"}, 128'(en_ok), 128'd1);
    chk({tag, "_ch_sel"}, 128'(ch_sel), 128'(m_chsel(code)));
  endtask

  function automatic int unsigned pick_code();
    int unsigned r, c;
    r = $urandom_range(0, 5);
    case (r)
      0: c = C_BYP;
      1: c = C_IDC;
      2: c = C_BLD;
      3, 4: c = CH_B + $urandom_range(0, CH_N - 1);
      default: begin
        c = $urandom_range(0, C_BLD - 1);
        if (c >= CH_B && c < CH_B + CH_N) c = CH_B + CH_N;
      end
    endcase
    return c;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b, e;
    int len;
    int unsigned code;
    logic [63:0] din;

    for (int k = 0; k < CH_N; k++) ch_cap_val[k] = 8'(k * 8'h11 + 8'h5A);
    trst_n = 1'b0;
    tms    = 1'b1;
    tdi    = 1'b0;
    repeat (3) @(posedge tck);
    #1;
    $display("rst state=%0h tdo=%0b en=%0b ch_sel=%0b", tap_st, tdo, tdo_en, ch_sel);
    chk("rst_state", 128'(tap_st), 128'(SCR1_TAP_STATE_RESET));
    chk("rst_tdo", {tdo, tdo_en}, 2'b00);
    chk("rst_ch", {ch_sel, ch_capture, ch_shift, ch_update}, '0);
    @(negedge tck);
    trst_n   = 1'b1;
    model_ir = C_IDC;
    step(1'b0);

    // IDCODE is the default instruction after reset
    dr_txn("idcode_rst", 32, 64'($urandom), -1);

    // Directed bypass: tdi 1,0,1,1 gives tdo 0,1,0,1
    ir_txn("bypass", C_BYP);
    dr_txn("bypass", 4, 64'b1101, -1);

    // Directed channel 2 scan
    ir_txn("ch2", CH_B + 2);
    chk("ch2_onehot", 128'(ch_sel), 128'b0100);
    dr_txn("ch2", 8, 64'($urandom), -1);

    // Unmapped code acts as BYPASS
    ir_txn("unmapped", 'h10);
    dr_txn("unmapped", 5, 64'($urandom), -1);

    // Build ID
    ir_txn("bld_id", C_BLD);
    dr_txn("bld_id", 32, 64'($urandom), 7);

    // Randomised instruction/data scans, some with a pause mid-shift
    for (int t = 0; t < 40; t++) begin
      code = pick_code();
      for (int k = 0; k < CH_N; k++) ch_cap_val[k] = 8'($urandom);
      ir_txn("rnd", code);
      len = int'(m_width(code)) + int'($urandom_range(0, 8));
      din = {32'($urandom), 32'($urandom)};
      dr_txn("rnd", len, din, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1);
    end

    // Async reset in the middle of a channel 1 Shift-DR
    ir_txn("trst", CH_B + 1);
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, b, e);
    #2;
    chk("trst_pre_shift", 128'(ch_shift), 128'd1);
    trst_n = 1'b0;
    #1;
    $display("trst state=%0h ch_shift=%0b ch_sel=%0b en=%0b", tap_st, ch_shift, ch_sel, tdo_en);
    chk("trst_shift_drop", 128'(ch_shift), 128'd0);
    chk("trst_ch_sel", 128'(ch_sel), 128'd0);
    chk("trst_state", 128'(tap_st), 128'(SCR1_TAP_STATE_RESET));
    chk("trst_tdo_en", 128'(tdo_en), 128'd0);
    @(negedge tck);
    trst_n   = 1'b1;
    model_ir = C_IDC;
    step(1'b0);
    dr_txn("after_trst", 32, 64'($urandom), -1);

    // Five TMS=1 from Pause-DR reach reset and restore IDCODE
    ir_txn("tms5", CH_B + 1);
    step(1'b1); step(1'b0); step(1'b0);
    tck_cycle(1'b1, 1'b0, b, e);
    step(1'b0); step(1'b0);
    repeat (5) step(1'b1);
    #1;
    $display("tms5 state=%0h ch_sel=%0b", tap_st, ch_sel);
    chk("tms5_state", 128'(tap_st), 128'(SCR1_TAP_STATE_RESET));
    chk("tms5_ch_sel", 128'(ch_sel), 128'd0);
    model_ir = C_IDC;
    step(1'b0);
    dr_txn("tms5_idcode", 32, 64'($urandom), -1);

    // Random TMS walks always end in reset after five ones
    for (int t = 0; t < 12; t++) begin
      len = int'($urandom_range(1, 20));
      for (int i = 0; i < len; i++) step(1'($urandom));
      repeat (5) step(1'b1);
      #1;
      $display("walk %0d len=%0d state=%0h", t, len, tap_st);
      chk("walk_reset", 128'(tap_st), 128'(SCR1_TAP_STATE_RESET));
    end
    model_ir = C_IDC;
    step(1'b0);
    dr_txn("walk_idcode", 32, 64'($urandom), -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scr1_tapc_mch.md
# scr1_tapc_mch

Parametrised multi-channel JTAG TAP controller; next generation of the SCR1 TAPC with configurable IR width, a configurable number of external DR channels and built-in IDCODE/BYPASS/BLD_ID registers. It sits between the chip JTAG pins and the debug-side DR owners (DMI, system control, scan-mapped registers). It runs the IEEE 1149.1 16-state FSM and routes capture/shift/update strobes to whichever channel the current instruction selects.

## Interface
Parameters:
- IR_WIDTH, 5, instruction register width (≥4).
- CH_NUM, 4, number of external DR channels (1..8).
- CH_BASE, 'h03, instruction code of channel 0; channel k uses CH_BASE+k; CH_BASE+CH_NUM-1 < 2^IR_WIDTH-3.
- IDCODE_VALUE, 32'hDEB01001, IDCODE DR value (bit 0 = 1).
- BLD_ID_VALUE, `SCR1_MIMPID, build-ID DR value.

Ports (one clock; reset is asynchronous and active-low):
- tapc_tck  in  1  JTAG clock; all state on rising edge except TDO path (falling edge).
- tapc_trst_n  in  1  asynchronous active-low reset.
- tapc_tms  in  1  mode select.
- tapc_tdi  in  1  serial data in.
- tapc_tdo  out  1  serial data out.
- tapc_tdo_en  out  1  output enable for TDO pad.
- ch_sel  out  CH_NUM  one-hot channel select decoded from IR; 0 when no channel selected.
- ch_capture  out  1  high in Capture-DR while a channel is selected.
- ch_shift  out  1  high in Shift-DR while a channel is selected.
- ch_update  out  1  high in Update-DR while a channel is selected.
- ch_tdi  out  1  copy of tapc_tdi to channels.
- ch_tdo  in  CH_NUM  serial out (LSB of shift register) of each channel.
- tapc_state  out  4  current FSM state (type_scr1_tap_state_e), for debug observation.

## Operation
- FSM: standard 16 states, standard TMS transitions; reset state RESET (Test-Logic-Reset).
- Instruction map: all-ones = BYPASS; all-ones−1 = IDCODE; all-ones−2 = BLD_ID; CH_BASE..CH_BASE+CH_NUM-1 = channels; any other code behaves as BYPASS.
- IR: IR_WIDTH shift register plus latched IR. IR_CAPTURE loads 'b…0001 (LSB pair 01). IR_SHIFT shifts tdi in at MSB, out at LSB. Latched IR updated at rising edge while in IR_UPDATE. In RESET latched IR forced to IDCODE.
- Internal DRs: BYPASS 1 bit, captures 0; IDCODE 32 bits, captures IDCODE_VALUE; BLD_ID 32 bits, captures BLD_ID_VALUE. Shift right, tdi into MSB. Update has no effect (read-only).
- Channels: strobes are combinational decodes of state register AND (|ch_sel); channel owns its shift register and shifts on rising edge when ch_shift.
- TDO source: IR_SHIFT → IR shift LSB; DR_SHIFT → selected internal DR LSB or ch_tdo[k].

## Timing
- Reset values: state RESET, latched IR IDCODE, IR shift reg 0, DRs 0, tapc_tdo 0, tapc_tdo_en 0, ch_sel 0, strobes 0.
- tapc_tdo/tapc_tdo_en registered on falling edge of tapc_tck; tdo_en =1 in half-cycle following a rising edge that leaves state in IR_SHIFT or DR_SHIFT, else 0.
- Five consecutive TMS=1 rising edges reach RESET from any state.
- ch_sel changes only at the rising edge leaving IR_UPDATE or on entering RESET; stable across an entire DR scan.
- tapc_trst_n assertion mid-scan: immediate return to reset values; channel strobes drop asynchronously; partially shifted data discarded.
- Pause/Exit states hold all shift registers.

## Structure
- New package scr1_tapc_mch_pkg: instruction-code offset constants (BYPASS/IDCODE/BLD_ID relative to all-ones), DR widths; reuse type_scr1_tap_state_e from scr1_tapc_pkg.
- Sub-module scr1_tapc_mch_fsm: state register and next-state logic only; top holds IR, internal DRs, decode and TDO mux.

## Test plan
- trst_n low then TMS=0 ×1, scan DR 32 bits → tapc_tdo returns 32'hDEB01001 LSB first (IDCODE default after reset).
- Shift IR 5 bits from idle → first two TDO bits 1,0 (capture 01), then remaining 0s.
- Load IR all-ones, shift DR with tdi pattern 1011 → TDO 0,1,0,1 (one-cycle bypass delay).
- Load IR CH_BASE+2 → ch_sel='b0100; 8-bit DR scan shows ch_capture 1 cycle, ch_shift 8 cycles, ch_update 1 cycle, TDO = ch_tdo[2].
- Load unmapped code 'h10 → ch_sel=0, behaves as BYPASS.
- Mid Shift-DR on channel 1, pulse trst_n low → ch_shift drops immediately, ch_sel=0, state RESET, tdo_en=0; also TMS=1 ×5 from DR_PAUSE → RESET, IR=IDCODE.
